gpio_port_bank: RTL

- Parametrised successor to the single fixed 8-bit PORTA tri-state hookup of the microcontroller top.
- Provides num_ports independent ports, each port_width bits wide, with these registers on the core I/O bus: PORTx, DDRx and PINx.
- Each pin input has a 2-flop synchroniser.
- Each port has a pin-change interrupt with a mask, an enable, a flag and a hardware acknowledge.
- Sits beside the core I/O slaves. portx/ddrx drive external tri_buf_vect instances at the top level.

---
 rtl/gpio_port_bank_pkg.sv | 27 ++
 rtl/gpio_port_bank_sync_edge.sv | 30 +++
 rtl/gpio_port_bank.sv | 124 ++++++++++++
 3 files changed

// File: rtl/gpio_port_bank_pkg.sv
// Shared constants and address-map helpers for the GPIO port bank.
package gpio_port_bank_pkg;

  localparam int c_gpio_pin_ofs       = 0;
  localparam int c_gpio_ddr_ofs       = 1;
  localparam int c_gpio_port_ofs      = 2;
  localparam int c_gpio_regs_per_port = 3;

  // Shared registers sit after the per-port PIN/DDR/PORT triplets.
  function automatic int gpio_pcmsk_ofs(input int num_ports);
    return c_gpio_regs_per_port * num_ports;
  endfunction

  function automatic int gpio_pcifr_ofs(input int num_ports);
    return 4 * num_ports;
  endfunction

  function automatic int gpio_pcicr_ofs(input int num_ports);
    return 4 * num_ports + 1;
  endfunction

  // First offset past the map.
  function automatic int gpio_map_end(input int num_ports);
    return 4 * num_ports + 2;
  endfunction

endpackage

// File: rtl/gpio_port_bank_sync_edge.sv
// Per-port 2-flop input synchroniser, previous-value flop and masked change detect.
module gpio_sync_edge #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [width-1:0] d,
  input  logic [width-1:0] mask,
  output logic [width-1:0] sync_q,
  output logic             chg
);

  logic [width-1:0] sync1, sync2, prev;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign sync_q = sync2;
  assign chg    = |((sync2 ^ prev) & mask);

endmodule

// File: rtl/gpio_port_bank.sv
// Multi-port GPIO bank on the core I/O bus: PIN/DDR/PORT per port plus pin-change IRQ.
// Build option GPIO_PIN_TOGGLE_EN: writes to PINx toggle the matching PORTx bits.
module gpio_port_bank
  import gpio_port_bank_pkg::*;
#(
  parameter int          num_ports  = 2,
  parameter int          port_width = 8,
  parameter logic [5:0]  base_adr   = 6'h10
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic [5:0]                      io_adr,
  input  logic                            io_iore,
  input  logic                            io_iowe,
  input  logic [7:0]                      io_dbus_in,
  output logic [7:0]                      io_dbus_out,
  output logic                            io_out_en,
  input  logic [num_ports*port_width-1:0] pin_in,
  output logic [num_ports*port_width-1:0] portx,
  output logic [num_ports*port_width-1:0] ddrx,
  output logic [num_ports-1:0]            pc_irq,
  input  logic [num_ports-1:0]            pc_irq_ack
);

  localparam int base = int'(base_adr);
  localparam logic [5:0] adr_pcifr = 6'(base + gpio_pcifr_ofs(num_ports));
  localparam logic [5:0] adr_pcicr = 6'(base + gpio_pcicr_ofs(num_ports));

  if (num_ports < 1 || num_ports > 8 || port_width < 1 || port_width > 8)
    $error("gpio_port_bank: num_ports and port_width must be 1..8");
  if (base + gpio_map_end(num_ports) > 64)
    $error("gpio_port_bank: register map does not fit below 6'h40");

  logic [num_ports-1:0][port_width-1:0] port_q, ddr_q, msk_q, pin_s;
  logic [num_ports-1:0]                 flag_q, en_q, chg, flag_d;
  logic [port_width-1:0]                din;
  logic [7:0]                           rd_data;
  logic                                 hit;

  assign din = io_dbus_in[port_width-1:0];

  for (genvar p = 0; p < num_ports; p++) begin : g_port
    gpio_sync_edge #(.width(port_width)) u_sync (
      .clk    (clk),
      .nrst   (nrst),
      .d      (pin_in[p*port_width +: port_width]),
      .mask   (msk_q[p]),
      .sync_q (pin_s[p]),
      .chg    (chg[p])
    );
  end

  function automatic logic [5:0] port_adr(input int p, input int ofs);
    return 6'(base + c_gpio_regs_per_port * p + ofs);
  endfunction

  function automatic logic [5:0] msk_adr(input int p);
    return 6'(base + gpio_pcmsk_ofs(num_ports) + p);
  endfunction

  always_comb begin
    hit     = 1'b0;
    rd_data = 8'h00;
    for (int p = 0; p < num_ports; p++) begin
      if (io_adr == port_adr(p, c_gpio_pin_ofs)) begin
        hit = 1'b1; rd_data = 8'(pin_s[p]);
      end
      if (io_adr == port_adr(p, c_gpio_ddr_ofs)) begin
        hit = 1'b1; rd_data = 8'(ddr_q[p]);
      end
      if (io_adr == port_adr(p, c_gpio_port_ofs)) begin
        hit = 1'b1; rd_data = 8'(port_q[p]);
      end
      if (io_adr == msk_adr(p)) begin
        hit = 1'b1; rd_data = 8'(msk_q[p]);
      end
    end
    if (io_adr == adr_pcifr) begin
      hit = 1'b1; rd_data = 8'(flag_q);
    end
    if (io_adr == adr_pcicr) begin
      hit = 1'b1; rd_data = 8'(en_q);
    end
  end

  assign io_out_en   = io_iore & hit;
  assign io_dbus_out = io_out_en ? rd_data : 8'h00;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      port_q <= '0;
      ddr_q  <= '0;
      msk_q  <= '0;
      en_q   <= '0;
    end else if (io_iowe) begin
      for (int p = 0; p < num_ports; p++) begin
        if (io_adr == port_adr(p, c_gpio_ddr_ofs))  ddr_q[p]  <= din;
        if (io_adr == port_adr(p, c_gpio_port_ofs)) port_q[p] <= din;
        if (io_adr == msk_adr(p))                   msk_q[p]  <= din;
`ifdef GPIO_PIN_TOGGLE_EN
        if (io_adr == port_adr(p, c_gpio_pin_ofs))  port_q[p] <= port_q[p] ^ din;
`endif
      end
      if (io_adr == adr_pcicr) en_q <= io_dbus_in[num_ports-1:0];
    end
  end

  // A new change always wins over a write-1 clear or an acknowledge.
  always_comb begin
    flag_d = chg | (flag_q & ~pc_irq_ack);
    if (io_iowe && io_adr == adr_pcifr)
      flag_d = chg | (flag_q & ~pc_irq_ack & ~io_dbus_in[num_ports-1:0]);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) flag_q <= '0;
    else       flag_q <= flag_d;
  end

  assign portx  = port_q;
  assign ddrx   = ddr_q;
  assign pc_irq = flag_q & en_q;

endmodule
